// File: rtl/crcu_apb_regs_if.sv
// APB3 bus bundle for the CRCU register block.
//   master: drives psel/penable/pwrite/paddr/pwdata, receives prdata/pready/pslverr
//   slave : the mirror image
interface crcu_apb_regs_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  prdata, pready, pslverr);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output prdata, pready, pslverr);
endinterface

// File: rtl/crcu_apb_regs.sv
// CRCU APB3 register block: control words for the reset/clock generators
// and reset-generator status for software.
//   CRCU_CLK, CRCU_RST_N : clock, async active-low reset
//   apb                  : APB3 slave port (8-bit byte address, 32-bit data)
//   rst_active           : reset generator output (same clock domain)
//   rst_ctl_reg          : {13'b0, DURATION, 1'b0, RST_EN, SW_RST pulse}
//   clk_ctl_reg          : {24'b0, EN}
// Map: 0x00 RST_CTL, 0x04 STATUS, 0x08 CLK_CTL, 0x0C ID (read-only).
module crcu_apb_regs #(
    parameter int          WAIT_STATES      = 0,
    parameter logic [15:0] DEF_RST_DURATION = 16'd16,
    parameter logic [7:0]  DEF_CLK_EN       = 8'hFF,
    parameter logic [31:0] BLOCK_ID         = 32'hC5C0_0100
) (
    input  logic                  CRCU_CLK,
    input  logic                  CRCU_RST_N,
    crcu_apb_regs_if.slave        apb,
    input  logic                  rst_active,
    output logic [31:0]           rst_ctl_reg,
    output logic [31:0]           clk_ctl_reg
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] dur_q, dur_d;
    logic        rst_en_q, rst_en_d;
    logic        sw_rst_q, sw_rst_d;
    logic [7:0]  clk_en_q, clk_en_d;
    logic        done_q, done_d;
    logic        act_q;

    logic        xfer_done, err, wr_commit;
    logic [1:0]  idx;
    logic [31:0] rdata;

    // ---------------- transfer FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (apb.psel && !apb.penable) begin
                cnt_d   = WS_LOAD;
                state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (!apb.psel) begin
                    state_d = S_IDLE;          // master gave up: abort
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd0) state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
        if (!CRCU_RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- decode / response ----------------
    // Completion needs a live access phase; a dropped psel in RESP aborts.
    assign xfer_done = (state_q == S_RESP) && apb.psel && apb.penable;
    assign idx       = apb.paddr[3:2];
    // RST_CTL is locked while the generator is mid-pulse.
    assign err = (apb.paddr[1:0] != 2'b00) || (apb.paddr > 8'h0C) ||
                 (apb.pwrite && idx == 2'd3) ||
                 (apb.pwrite && idx == 2'd0 && rst_active);
    assign wr_commit = xfer_done && apb.pwrite && !err;

    always_comb begin
        rdata = 32'h0;
        case (idx)
            2'd0: rdata = {13'b0, dur_q, 1'b0, rst_en_q, 1'b0};
            2'd1: rdata = {30'b0, done_q, rst_active};
            2'd2: rdata = {24'b0, clk_en_q};
            2'd3: rdata = BLOCK_ID;
            default: rdata = 32'h0;
        endcase
    end

    assign apb.pready  = xfer_done;
    assign apb.pslverr = xfer_done && err;
    assign apb.prdata  = (xfer_done && !err) ? rdata : 32'h0;

    // ---------------- register updates ----------------
    always_comb begin
        dur_d    = dur_q;
        rst_en_d = rst_en_q;
        clk_en_d = clk_en_q;
        done_d   = done_q;
        sw_rst_d = 1'b0;
        if (wr_commit) begin
            case (idx)
                2'd0: begin
                    dur_d    = apb.pwdata[18:3];
                    rst_en_d = apb.pwdata[1];
                    sw_rst_d = apb.pwdata[0];
                end
                2'd1: if (apb.pwdata[1]) done_d = 1'b0;
                2'd2: clk_en_d = apb.pwdata[7:0];
                default: ;
            endcase
        end
        // Falling edge of rst_active overrides a same-cycle clear.
        if (act_q && !rst_active) done_d = 1'b1;
    end

    always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
        if (!CRCU_RST_N) begin
            dur_q    <= DEF_RST_DURATION;
            rst_en_q <= 1'b1;
            sw_rst_q <= 1'b0;
            clk_en_q <= DEF_CLK_EN;
            done_q   <= 1'b0;
            act_q    <= 1'b0;
        end else begin
            dur_q    <= dur_d;
            rst_en_q <= rst_en_d;
            sw_rst_q <= sw_rst_d;
            clk_en_q <= clk_en_d;
            done_q   <= done_d;
            act_q    <= rst_active;
        end
    end

    assign rst_ctl_reg = {13'b0, dur_q, 1'b0, rst_en_q, sw_rst_q};
    assign clk_ctl_reg = {24'b0, clk_en_q};

endmodule

// File: tb/tb_crcu_apb_regs.sv
module tb_crcu_apb_regs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst_active;
    logic        psel0, psel3, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] rst0, clk0, rst3, clk3;

    crcu_apb_regs_if if0();
    crcu_apb_regs_if if3();
    assign if0.psel = psel0;   assign if3.psel = psel3;
    assign if0.penable = penable; assign if3.penable = penable;
    assign if0.pwrite = pwrite;   assign if3.pwrite = pwrite;
    assign if0.paddr = paddr;     assign if3.paddr = paddr;
    assign if0.pwdata = pwdata;   assign if3.pwdata = pwdata;

    crcu_apb_regs #(.WAIT_STATES(0)) u_dut0 (
        .CRCU_CLK(clk), .CRCU_RST_N(rst_n), .apb(if0), .rst_active(rst_active),
        .rst_ctl_reg(rst0), .clk_ctl_reg(clk0));
    crcu_apb_regs #(.WAIT_STATES(3)) u_dut3 (
        .CRCU_CLK(clk), .CRCU_RST_N(rst_n), .apb(if3), .rst_active(rst_active),
        .rst_ctl_reg(rst3), .clk_ctl_reg(clk3));

    int ntot = 0, npass = 0;

    // Reference model, index 0 = no-wait instance, 1 = 3-wait instance.
    int unsigned m_dur[2];
    bit          m_en[2];
    int unsigned m_clk[2];
    bit          m_done[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic rdy(input int k);
        return (k == 0) ? if0.pready : if3.pready;
    endfunction
    function automatic logic [31:0] rctl(input int k);
        return (k == 0) ? rst0 : rst3;
    endfunction
    function automatic logic [31:0] cctl(input int k);
        return (k == 0) ? clk0 : clk3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_dur[k] = 16; m_en[k] = 1; m_clk[k] = 8'hFF; m_done[k] = 0;
        end
    endtask

    function automatic logic [31:0] m_rst_word(input int k);
        return 32'(m_dur[k] * 8 + (m_en[k] ? 2 : 0));
    endfunction

    // One APB transfer; returns sampled read data, error and wait count.
    task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input bit drop, output logic [31:0] rd, output logic er, output int waits);
        @(negedge clk);
        if (k == 0) psel0 = 1; else psel3 = 1;
        penable = 0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1;
        waits = 0;
        forever begin
            #1;
            if (rdy(k)) break;
            if (waits >= 20) begin chk("pready_timeout", {31'b0, rdy(k)}, 32'h1); break; end
            @(negedge clk);
            waits++;
        end
        if (drop) begin rst_active = 0; #1; end
        rd = (k == 0) ? if0.prdata : if3.prdata;
        er = (k == 0) ? if0.pslverr : if3.pslverr;
        @(posedge clk);
        #1;
        psel0 = 0; psel3 = 0; penable = 0;
    endtask

    // Transfer + model prediction + checks of response and register outputs.
    task automatic op(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input bit drop, output logic [31:0] rd);
        bit act, e_err, pulse;
        logic [31:0] e_rd;
        logic er;
        int waits;
        int unsigned ai;
        ai = a;
        act = drop ? 1'b0 : rst_active;
        e_err = (ai % 4 != 0) || (ai > 12) || (wr && ai == 12) || (wr && ai == 0 && act);
        case (ai)
            0:  e_rd = m_rst_word(k);
            4:  e_rd = 32'((m_done[k] ? 2 : 0) + (act ? 1 : 0));
            8:  e_rd = 32'(m_clk[k]);
            12: e_rd = 32'hC5C0_0100;
            default: e_rd = 0;
        endcase
        if (e_err) e_rd = 0;
        xfer(k, wr, a, d, drop, rd, er, waits);
        chk($sformatf("waits k%0d a%02h", k, a), 32'(waits), (k == 0) ? 32'd0 : 32'd3);
        chk($sformatf("pslverr k%0d a%02h w%0d", k, a, wr), {31'b0, er}, {31'b0, e_err});
        if (!wr) chk($sformatf("prdata k%0d a%02h", k, a), rd, e_rd);
        pulse = 0;
        if (wr && !e_err) begin
            if (ai == 0) begin
                m_dur[k] = (d >> 3) & 32'hFFFF; m_en[k] = d[1]; pulse = d[0];
            end else if (ai == 4) begin
                if (d[1]) m_done[k] = 0;
            end else if (ai == 8) m_clk[k] = d & 32'hFF;
        end
        if (drop) begin m_done[0] = 1; m_done[1] = 1; end
        chk($sformatf("rst_ctl k%0d", k), rctl(k), m_rst_word(k) + (pulse ? 1 : 0));
        chk($sformatf("clk_ctl k%0d", k), cctl(k), 32'(m_clk[k]));
        @(posedge clk); #1;
        chk($sformatf("sw_rst_end k%0d", k), {31'b0, rctl(k)[0]}, 32'h0);
    endtask

    task automatic set_active(input bit v);
        bit old;
        @(negedge clk);
        old = rst_active;
        rst_active = v;
        @(posedge clk); #1;
        if (old && !v) begin m_done[0] = 1; m_done[1] = 1; end
    endtask

    logic [31:0] rd;
    logic [7:0]  addrs[8];

    initial begin
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h02, 8'h41, 8'hFC};
        psel0 = 0; psel3 = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        rst_active = 0;
        rst_n = 0;
        model_reset();
        #12;
        chk("rst_prdata", if0.prdata, 32'h0);
        chk("rst_pready", {31'b0, if3.pready}, 32'h0);
        chk("rst_pslverr", {31'b0, if0.pslverr}, 32'h0);
        chk("rst_rst_ctl", rst0, 32'h0000_0082);
        chk("rst_clk_ctl", clk3, 32'h0000_00FF);
        @(negedge clk); rst_n = 1;

        // Reset readback and SW_RST write
        op(0, 0, 8'h00, 0, 0, rd);            chk("rd_rst_ctl_def", rd, 32'h0000_0082);
        op(0, 1, 8'h00, 32'h0000_0141, 0, rd);
        op(0, 0, 8'h00, 0, 0, rd);            chk("rd_rst_ctl_new", rd, 32'h0000_0140);

        // Lock while rst_active, DONE sticky and W1C
        set_active(1);
        op(0, 1, 8'h00, 32'h0000_0013, 0, rd);
        chk("locked_rst_ctl", rst0, 32'h0000_0140);
        set_active(0);
        op(0, 0, 8'h04, 0, 0, rd);            chk("status_done", rd, 32'h2);
        op(0, 1, 8'h04, 32'h0, 0, rd);
        op(0, 0, 8'h04, 0, 0, rd);            chk("status_w0_keep", rd, 32'h2);
        op(0, 1, 8'h04, 32'h2, 0, rd);
        op(0, 0, 8'h04, 0, 0, rd);            chk("status_clr", rd, 32'h0);

        // Wait states and ID
        op(1, 0, 8'h0C, 0, 0, rd);            chk("id_ws3", rd, 32'hC5C0_0100);
        op(1, 1, 8'h0C, 32'h1234, 0, rd);

        // Address errors and CLK_CTL masking
        op(0, 0, 8'h10, 0, 0, rd);
        op(0, 0, 8'h02, 0, 0, rd);
        op(0, 1, 8'h08, 32'hFFFF_FF5A, 0, rd); chk("clk_ctl_5a", clk0, 32'h0000_005A);

        // DONE set and W1C in the same cycle: set wins
        set_active(1);
        op(0, 1, 8'h04, 32'h2, 1, rd);
        op(0, 0, 8'h04, 0, 0, rd);            chk("done_set_wins", rd, 32'h2);

        // Reset during a WAIT cycle
        op(1, 1, 8'h08, 32'h33, 0, rd);
        @(negedge clk);
        psel3 = 1; penable = 0; pwrite = 1; paddr = 8'h08; pwdata = 32'h77;
        @(negedge clk);
        penable = 1;
        #1;
        chk("mid_wait_pready", {31'b0, if3.pready}, 32'h0);
        rst_n = 0;
        #1;
        chk("mid_rst_clk_ctl", clk3, 32'h0000_00FF);
        chk("mid_rst_pready", {31'b0, if3.pready}, 32'h0);
        model_reset();
        psel3 = 0; penable = 0;
        @(negedge clk); rst_n = 1;
        op(1, 0, 8'h08, 0, 0, rd);            chk("post_rst_rd", rd, 32'h0000_00FF);

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) set_active(~rst_active);
            op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               addrs[$urandom_range(0, 7)], $urandom, 0, rd);
        end
        set_active(0);
        op(1, 0, 8'h04, 0, 0, rd);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/crcu_apb_regs.md
Name: crcu_apb_regs

Overview:
APB3 slave register block for the CRCU (Clock & Reset Control Unit).
- Holds the control words consumed by the CRCU reset and clock generators, principally rst_ctl_reg.
- Reports reset-generator status back to software.
- Sits between the SoC APB fabric and the CRCU reset/clock generators; it is the software-facing writer of the registers those generators read.

Parameters:
WAIT_STATES, 0, pready-low cycles inserted in each access phase (0..7)
DEF_RST_DURATION, 16'd16, reset value of RST_CTL.DURATION
DEF_CLK_EN, 8'hFF, reset value of CLK_CTL.EN
BLOCK_ID, 32'hC5C0_0100, value returned by the ID register

Ports:
CRCU_CLK  input  1  block clock; the APB clock is the same clock
CRCU_RST_N  input  1  asynchronous active-low reset
psel  input  1  APB select
penable  input  1  APB enable
pwrite  input  1  1=write, 0=read
paddr  input  8  byte address
pwdata  input  32  write data
prdata  output  32  read data, valid when pready=1
pready  output  1  access-phase completion
pslverr  output  1  error response, valid when pready=1
rst_active  input  1  reset output of the CRCU reset generator (same clock domain)
rst_ctl_reg  output  32  RST_CTL register contents to the reset generator
clk_ctl_reg  output  32  CLK_CTL register contents to the clock generator

Behaviour:
- Reset: one clock, CRCU_RST_N asynchronous active-low. While CRCU_RST_N=0:
  - prdata=0, pready=0, pslverr=0.
  - rst_ctl_reg = {13'b0, DEF_RST_DURATION, 1'b0, 1'b1, 1'b0}.
  - clk_ctl_reg = {24'b0, DEF_CLK_EN}.
  - STATUS.DONE=0; rst_active_q=0; FSM in IDLE.
- Register map (word aligned; paddr[1:0] != 0 is an error):
  - 0x00 RST_CTL:
    - [0] SW_RST: write 1 gives a one-cycle pulse on rst_ctl_reg[0] in the cycle after commit; it reads back as 0.
    - [1] RST_EN: R/W.
    - [2] reserved: read-as-zero, write ignored.
    - [18:3] DURATION: R/W.
    - [31:19]: read-as-zero, write ignored.
  - 0x04 STATUS:
    - [0] ACTIVE: read-only, equals rst_active sampled in the access cycle.
    - [1] DONE: sticky; set on the 1->0 transition of rst_active (rst_active_q & ~rst_active); write 1 to clear. A write of 0 leaves it unchanged.
    - Other bits: read-as-zero, write ignored.
  - 0x08 CLK_CTL: [7:0] EN R/W; [31:8] read-as-zero, write ignored.
  - 0x0C ID: read-only, returns BLOCK_ID.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on psel & ~penable (setup phase), go to WAIT if WAIT_STATES>0, else RESP. Load wait counter = WAIT_STATES-1.
  - WAIT: pready=0. Decrement the 3-bit counter each cycle; go to RESP after the cycle in which it reads 0.
  - RESP: entered only with psel & penable. pready=1 for exactly one cycle; the write commits in this cycle; then go to IDLE.
  - With WAIT_STATES=0 the transfer completes in the first access cycle (2 APB cycles total).
  - psel dropping in WAIT or RESP: abort to IDLE, no commit, pready=0.
- Error conditions (pslverr=1 in the RESP cycle, no register changes):
  - Unmapped address (>0x0C) or misaligned address.
  - Write to ID.
  - Write to RST_CTL while rst_active=1. This locks DURATION mid-pulse and also blocks SW_RST.
  - A read error returns prdata=0.
- prdata is driven only in the RESP cycle and is 0 otherwise. pslverr is 0 outside RESP.
- Simultaneous events:
  - DONE set event in the same cycle as a W1C write: set wins, DONE=1.
  - SW_RST write when the previous pulse has already cleared: a new pulse is issued. Back-to-back SW_RST writes give separate pulses, at least 2 cycles apart by protocol.
- Mid-transfer reset: CRCU_RST_N asserted during WAIT or RESP returns the FSM to IDLE, discards the access, and restores all reset values.

Test Plan:
- Reset then read 0x00 with WAIT_STATES=0 -> pready in the 2nd APB cycle; prdata=32'h0000_0082 (DURATION=16, RST_EN=1); pslverr=0.
- Write 0x00 = 32'h0000_0141 (DURATION=40, RST_EN=0, SW_RST=1) with rst_active=0 -> rst_ctl_reg[0]=1 for exactly one cycle after commit; readback 32'h0000_0140.
- Hold rst_active=1, write 0x00 -> pslverr=1, rst_ctl_reg unchanged, no SW_RST pulse. Drop rst_active -> STATUS reads 32'h2. Write 0x04=32'h2 -> STATUS reads 0.
- WAIT_STATES=3, read 0x0C -> pready low for 3 access cycles, then high for 1 cycle with prdata=32'hC5C0_0100. Write 0x0C -> pslverr=1.
- Read 0x10 and 0x02 -> pslverr=1, prdata=0. Write 0x08=32'hFFFF_FF5A -> clk_ctl_reg=32'h0000_005A.
- Assert CRCU_RST_N=0 during a WAIT cycle of a write to 0x08 -> clk_ctl_reg=32'hFF, pready=0, FSM in IDLE; the next transfer completes normally.
